keypad_move_entry: RTL
======================

// Module: keypad_move_entry
// PURPOSE
//  Upstream input stage of the tic-tac-toe chip: scans a 3x3 push-button matrix and debounces it.
//  Turns a press into one move {playerInput, playerWrite} for the game core.
//  Rejects presses on occupied squares or while moves are disabled.
// PARAMETERS
//  SCAN_CYCLES     4  clock cycles each column is driven; full scan = 3*SCAN_CYCLES
//  DEBOUNCE_SCANS  3  consecutive identical full-scan results needed to accept press or release
// PORTS
//  ph1          in   1   sole clock; one clock, all state on rising ph1 (ph2 not used)
//  reset        in   1   synchronous, active-high
//  rowSense     in   3   keypad rows, active-high, pre-synchronised
//  gBoard       in   18  board from game core; square i = gBoard[2i+1:2i], 00 = empty
//  moveEnable   in   1   high while core accepts a move
//  colDrive     out  3   one-hot active-high column strobe
//  playerInput  out  4   square index 0..8 = row*3+col; held until next accepted move
//  playerWrite  out  1   one-cycle pulse, move valid
//  reject       out  1   one-cycle pulse, press refused
// BEHAVIOUR
//  Reset: colDrive=001, playerInput=0, playerWrite=0, reject=0, all counters 0, FSM IDLE.
//  Scan:
//   - col c is driven for SCAN_CYCLES cycles, order 0,1,2,0...
//   - rowSense is sampled on the last cycle of each slot.
//   - At the end of the col-2 slot a scan result is produced:
//     NONE (0 keys), KEY(idx) (exactly 1 key), MULTI (>=2 keys; treated as NONE).
//  Debounce:
//   - stableCnt counts consecutive identical scan results and saturates at DEBOUNCE_SCANS.
//   - A result differing from the previous one reloads stableCnt to 1.
//  FSM:
//   - IDLE: on reaching DEBOUNCE_SCANS consecutive KEY(idx), go to CHECK with idx latched.
//   - CHECK, one cycle:
//     - moveEnable=1 and square idx == 00: set playerInput=idx, pulse playerWrite next cycle.
//     - Otherwise: pulse reject.
//     - Either way go to WAIT_RELEASE.
//   - WAIT_RELEASE: on DEBOUNCE_SCANS consecutive NONE, go to IDLE.
//     A changed key while waiting never issues a move; the key must be released first.
//  Latency: playerWrite/reject rises 2 cycles after the final sampling cycle of the qualifying
//   scan; exactly one pulse per press, whatever the hold time.
//  gBoard and moveEnable are evaluated only in CHECK; changes elsewhere are ignored.
//  Scan counter wraps modulo 3*SCAN_CYCLES and never stalls. Scanning continues in all states.
//  Reset mid-operation: returns to IDLE with no pulse. A key held through reset is accepted
//   once, after DEBOUNCE_SCANS scans.
//  Widths: slot counter $clog2(SCAN_CYCLES), stableCnt $clog2(DEBOUNCE_SCANS+1);
//   idx = row*3+col, always <=8.
//  playerWrite and reject are never high in the same cycle.
// STRUCTURE
//  tictactoe_pkg:
//   - NUM_SQUARES=9
//   - SQ_EMPTY=2'b00, SQ_P1=2'b01, SQ_P2=2'b10
//   - typedef enum {IDLE, CHECK, WAIT_RELEASE} entry_state_t
//   - typedef enum {SCAN_NONE, SCAN_KEY, SCAN_MULTI} scan_kind_t
//  Sub-module keypad_scanner:
//   - owns the slot counter and colDrive.
//   - outputs scanDone pulse, scan_kind_t and idx[3:0].
//  The top level holds the debounce counter, FSM and output registers.
// TESTING (SCAN_CYCLES=4, DEBOUNCE_SCANS=3, scan period 12 cycles)
//  1. gBoard=0, moveEnable=1, hold row1/col1 for 200 cycles -> one playerWrite, playerInput=4,
//     within 36+14 cycles of press; no second pulse.
//  2. Toggle row0 (square 2 on col2) every 5 cycles for 40 cycles, then hold -> no pulse during
//     bounce; one playerWrite with playerInput=2.
//  3. gBoard[9:8]=01, press square 4 -> one reject pulse, playerWrite=0, playerInput unchanged.
//  4. Press squares 0 and 8 together for 100 cycles -> no playerWrite, no reject.
//  5. moveEnable=0, press square 6 -> reject. Release, raise moveEnable, press again ->
//     playerWrite with playerInput=6.
//  6. Assert reset 20 cycles into a press on square 3 -> colDrive=001, no pulse. Key still held
//     after reset -> one playerWrite with playerInput=3.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe chip.
package tictactoe_pkg;

  localparam int unsigned NUM_SQUARES = 9;

  localparam logic [1:0] SQ_EMPTY = 2'b00;
  localparam logic [1:0] SQ_P1    = 2'b01;
  localparam logic [1:0] SQ_P2    = 2'b10;

  typedef enum logic [1:0] {IDLE, CHECK, WAIT_RELEASE} entry_state_t;
  typedef enum logic [1:0] {SCAN_NONE, SCAN_KEY, SCAN_MULTI} scan_kind_t;

  // Occupancy of square idx; constant-index loop keeps the part-select static.
  function automatic logic [1:0] squareAt(input logic [2*NUM_SQUARES-1:0] board,
                                          input logic [3:0] idx);
    logic [1:0] sq;
    sq = SQ_EMPTY;
    for (int i = 0; i < NUM_SQUARES; i++) begin
      if (idx == 4'(i)) sq = board[2*i +: 2];
    end
    return sq;
  endfunction

endpackage

// File: rtl/keypad_move_entry_if.sv
// Keypad matrix and game-core move signals of the keypad entry stage.
interface keypad_move_entry_if;
  import tictactoe_pkg::*;

  logic [2:0]               rowSense;
  logic [2:0]               colDrive;
  logic [2*NUM_SQUARES-1:0] gBoard;
  logic                     moveEnable;
  logic [3:0]               playerInput;
  logic                     playerWrite;
  logic                     reject;

  modport master (
    output rowSense, gBoard, moveEnable,
    input  colDrive, playerInput, playerWrite, reject
  );

  modport slave (
    input  rowSense, gBoard, moveEnable,
    output colDrive, playerInput, playerWrite, reject
  );

endinterface

// File: rtl/keypad_scanner.sv
// Column-strobing 3x3 keypad scanner; classifies each full scan as none, one key or several.
module keypad_scanner
  import tictactoe_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES = 4
) (
  input  logic       ph1,
  input  logic       reset,
  input  logic [2:0] rowSense,
  output logic [2:0] colDrive,
  output logic       scanDone,
  output scan_kind_t scanKind,
  output logic [3:0] scanIdx
);

  localparam int unsigned SlotW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  logic [SlotW-1:0]       slotCnt;
  logic [1:0]             colIdx;
  logic [NUM_SQUARES-1:0] keysQ, keysD;
  logic [3:0]             hits;
  logic                   lastSlot;

  assign lastSlot = (slotCnt == SlotW'(SCAN_CYCLES - 1));
  assign colDrive = 3'b001 << colIdx;
  assign scanDone = lastSlot && (colIdx == 2'd2);

  // The col-2 sample is folded in combinationally so the result is ready in its sampling cycle.
  always_comb begin
    keysD = keysQ;
    if (lastSlot) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          if (colIdx == 2'(c)) keysD[r*3+c] = rowSense[r];
        end
      end
    end
  end

  always_comb begin
    hits    = 4'd0;
    scanIdx = 4'd0;
    for (int i = 0; i < NUM_SQUARES; i++) begin
      if (keysD[i]) begin
        hits    = hits + 4'd1;
        scanIdx = 4'(i);
      end
    end
    if (hits == 4'd0)      scanKind = SCAN_NONE;
    else if (hits == 4'd1) scanKind = SCAN_KEY;
    else                   scanKind = SCAN_MULTI;
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      slotCnt <= '0;
      colIdx  <= 2'd0;
      keysQ   <= '0;
    end else if (lastSlot) begin
      slotCnt <= '0;
      colIdx  <= (colIdx == 2'd2) ? 2'd0 : colIdx + 2'd1;
      keysQ   <= keysD;
    end else begin
      slotCnt <= slotCnt + SlotW'(1);
    end
  end

endmodule

// File: rtl/keypad_move_entry.sv
// Keypad move entry: debounces scan results and turns each accepted press into one move or reject.
module keypad_move_entry
  import tictactoe_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES    = 4,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input logic                ph1,
  input logic                reset,
  keypad_move_entry_if.slave io
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);

  logic         scanDone;
  scan_kind_t   scanKind, effKind, lastKind;
  logic [3:0]   scanIdx, effIdx, lastIdx;
  logic [CntW-1:0] stableCnt, cntNext;
  logic         sameResult, debounced;

  entry_state_t stateQ, stateD;
  logic [3:0]   heldIdxQ, heldIdxD;
  logic [3:0]   inputQ, inputD;
  logic         writeQ, writeD;
  logic         rejectQ, rejectD;

  keypad_scanner #(
    .SCAN_CYCLES(SCAN_CYCLES)
  ) u_scanner (
    .ph1      (ph1),
    .reset    (reset),
    .rowSense (io.rowSense),
    .colDrive (io.colDrive),
    .scanDone (scanDone),
    .scanKind (scanKind),
    .scanIdx  (scanIdx)
  );

  // Multi-key scans debounce as "no key"; idx is zeroed so results compare cleanly.
  assign effKind    = (scanKind == SCAN_MULTI) ? SCAN_NONE : scanKind;
  assign effIdx     = (effKind == SCAN_KEY) ? scanIdx : 4'd0;
  assign sameResult = (effKind == lastKind) && (effIdx == lastIdx);

  always_comb begin
    if (!sameResult)                              cntNext = CntW'(1);
    else if (stableCnt == CntW'(DEBOUNCE_SCANS)) cntNext = stableCnt;
    else                                          cntNext = stableCnt + CntW'(1);
  end

  assign debounced = scanDone && (cntNext == CntW'(DEBOUNCE_SCANS));

  always_comb begin
    stateD   = stateQ;
    heldIdxD = heldIdxQ;
    inputD   = inputQ;
    writeD   = 1'b0;
    rejectD  = 1'b0;
    case (stateQ)
      IDLE: begin
        if (debounced && effKind == SCAN_KEY) begin
          stateD   = CHECK;
          heldIdxD = effIdx;
        end
      end
      CHECK: begin
        if (io.moveEnable && squareAt(io.gBoard, heldIdxQ) == SQ_EMPTY) begin
          writeD = 1'b1;
          inputD = heldIdxQ;
        end else begin
          rejectD = 1'b1;
        end
        stateD = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (debounced && effKind == SCAN_NONE) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      stateQ    <= IDLE;
      heldIdxQ  <= 4'd0;
      inputQ    <= 4'd0;
      writeQ    <= 1'b0;
      rejectQ   <= 1'b0;
      lastKind  <= SCAN_NONE;
      lastIdx   <= 4'd0;
      stableCnt <= '0;
    end else begin
      stateQ   <= stateD;
      heldIdxQ <= heldIdxD;
      inputQ   <= inputD;
      writeQ   <= writeD;
      rejectQ  <= rejectD;
      if (scanDone) begin
        lastKind  <= effKind;
        lastIdx   <= effIdx;
        stableCnt <= cntNext;
      end
    end
  end

  assign io.playerInput = inputQ;
  assign io.playerWrite = writeQ;
  assign io.reject      = rejectQ;

endmodule
